// File: rtl/fpu16_accumulator_if.sv
// ---------------------------------------------------------------------------
// fpu16_accumulator_if
// Stream bundle between an upstream fpu16_multiplier, the accumulator and its
// downstream consumer.
//
// Signals:
//   in_valid  : product beat offered by the producer
//   in_ready  : accumulator can take a beat this cycle
//   in_data   : binary16 product
//   in_last   : final term of the current sum
//   out_valid : completed sum available
//   out_ready : consumer takes the sum
//   out_sum   : binary16 accumulated result
//   out_count : number of terms folded into out_sum
//
// Modports:
//   master : the environment side (drives the input beat and out_ready)
//   slave  : the accumulator side
// ---------------------------------------------------------------------------
interface fpu16_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/fpu16_accumulator.sv
// ---------------------------------------------------------------------------
// fpu16_accumulator
// Folds a stream of binary16 products into one binary16 sum. Each sum starts
// on the first beat accepted in IDLE and ends on the beat flagged in_last. The
// finished sum is then held until the consumer takes it.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fpu16_accumulator_if.slave (input beat stream + result stream)
//
// Optional feature:
//   FPU16_ACC_SAT_EN : when defined, a finite overflow gives the signed maximum
//                      finite value instead of a signed infinity.
// ---------------------------------------------------------------------------
module fpu16_accumulator #(
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  fpu16_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state;
  state_t           next_state;
  logic             ready_q;
  logic [15:0]      acc;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic [15:0]      add_a;
  logic [15:0]      add_res;

  // Single-cycle binary16 adder with round-to-nearest-even. Subnormal operands
  // are treated as signed zero. The smaller operand is aligned into a 14-bit
  // field that holds hidden bit, mantissa, guard, round and sticky. Bits shifted
  // out beyond the field are folded into the sticky LSB. After the add or
  // subtract, the result is normalised. It is then rounded to 11 significant bits.
  // A result below the smallest normal is always exact, because both inputs are
  // multiples of 2^-24, so flushing it to +0 never conflicts with rounding.
  function automatic logic [15:0] fp16_add(input logic [15:0] a,
                                           input logic [15:0] b);
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              swap, sub, s_big, round_up;
    logic [4:0]        e_big, e_small, diff;
    logic [9:0]        m_big, m_small;
    logic [13:0]       sig_big, aligned, norm;
    logic [27:0]       shifted;
    logic [14:0]       raw;
    logic [11:0]       mant_r;
    logic signed [6:0] exp_n;
    int                lz;
    logic [15:0]       res;

    a_nan  = (&a[14:10]) & (|a[9:0]);
    b_nan  = (&b[14:10]) & (|b[9:0]);
    a_inf  = (&a[14:10]) & ~(|a[9:0]);
    b_inf  = (&b[14:10]) & ~(|b[9:0]);
    a_zero = ~(|a[14:10]);
    b_zero = ~(|b[14:10]);
    res    = 16'h0000;

    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      res = 16'h7E00;
    end else if (a_inf) begin
      res = {a[15], 15'h7C00};
    end else if (b_inf) begin
      res = {b[15], 15'h7C00};
    end else if (a_zero && b_zero) begin
      res = {a[15] & b[15], 15'h0000};
    end else if (a_zero) begin
      res = b;
    end else if (b_zero) begin
      res = a;
    end else begin
      swap    = b[14:0] > a[14:0];
      s_big   = swap ? b[15]    : a[15];
      e_big   = swap ? b[14:10] : a[14:10];
      m_big   = swap ? b[9:0]   : a[9:0];
      e_small = swap ? a[14:10] : b[14:10];
      m_small = swap ? a[9:0]   : b[9:0];
      diff    = e_big - e_small;
      sub     = a[15] ^ b[15];

      sig_big = {1'b1, m_big, 3'b000};
      shifted = {1'b1, m_small, 3'b000, 14'h0000} >> ((diff > 5'd15) ? 5'd15 : diff);
      aligned = shifted[27:14] | {13'h0000, |shifted[13:0]};

      raw = sub ? ({1'b0, sig_big} - {1'b0, aligned})
                : ({1'b0, sig_big} + {1'b0, aligned});
      exp_n = 7'({2'b00, e_big});

      if (raw == 15'h0000) begin
        res = 16'h0000;
      end else begin
        if (raw[14]) begin
          norm  = {raw[14:2], raw[1] | raw[0]};
          exp_n = exp_n + 7'sd1;
        end else begin
          lz = 0;
          for (int i = 0; i < 14; i++) begin
            if (raw[i]) lz = 13 - i;
          end
          norm  = raw[13:0] << lz;
          exp_n = exp_n - 7'(lz);
        end

        round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
        mant_r   = {1'b0, norm[13:3]} + {11'h000, round_up};
        if (mant_r[11]) begin
          mant_r = mant_r >> 1;
          exp_n  = exp_n + 7'sd1;
        end

        if (exp_n <= 7'sd0) begin
          res = 16'h0000;
        end else if (exp_n >= 7'sd31) begin
`ifdef FPU16_ACC_SAT_EN
          res = {s_big, 15'h7BFF};
`else
          res = {s_big, 15'h7C00};
`endif
        end else begin
          res = {s_big, exp_n[4:0], mant_r[9:0]};
        end
      end
    end
    return res;
  endfunction

  // Next-state logic. A beat transfers only when the registered ready and
  // in_valid coincide. A new sum starts from +0, so the first term goes
  // through the same adder as later terms. That keeps NaN and subnormal
  // handling uniform.
  always_comb begin
    next_state = state;
    accept     = bus.in_valid & ready_q;
    add_a      = (state == IDLE) ? 16'h0000 : acc;
    case (state)
      IDLE, ACC: begin
        if (accept) next_state = bus.in_last ? HOLD : ACC;
      end
      HOLD: begin
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign add_res = fp16_add(add_a, bus.in_data);

  // State register. in_ready is registered from the next state. This keeps it
  // low during reset, brings it high on the first edge after reset releases,
  // and raises it only in the cycle after a result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state != HOLD);
    end
  end

  // Accumulator and term counter. Both change only on an accepted beat, so
  // they stay frozen in HOLD and across bubbles. The counter sticks at its
  // maximum value rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= 16'h0000;
      count <= '0;
    end else if (accept) begin
      acc <= add_res;
      if (state == IDLE) begin
        count <= CNT_W'(1);
      end else if (!(&count)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = acc;
  assign bus.out_count = count;

endmodule

// File: tb/tb_fpu16_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fpu16_accumulator
// Self-checking bench for fpu16_accumulator. Directed sums exercise the
// corner cases. Randomised sums are checked against a reference that works
// with real-valued arithmetic and explicit nearest-even rounding.
// Define FPU16_ACC_SAT_EN for both the bench and the design to select the
// saturating overflow behaviour.
// ---------------------------------------------------------------------------
module tb_fpu16_accumulator;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_acc = 16'h0000;
  int          model_cnt = 0;
  bit          model_first = 1'b1;

  fpu16_accumulator_if #(.CNT_W(CNT_W)) bus ();

  fpu16_accumulator #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // A watchdog stops the run even if the handshake logic locks up.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) begin
      for (int i = 0; i < k; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -k; i++) r = r / 2.0;
    end
    return r;
  endfunction

  // Value of a finite half-precision word. Subnormals count as zero.
  function automatic real toReal(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) return 0.0;
    v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
    return h[15] ? -v : v;
  endfunction

  // Round an exact nonzero real to binary16, nearest-even, with underflow to +0.
  function automatic logic [15:0] fromReal(input real x);
    bit  s;
    real ax, m, frac;
    int  e, fi;
    s  = (x < 0.0);
    ax = s ? -x : x;
    if (ax < pow2(-14)) return 16'h0000;
    e = -14;
    while (ax >= pow2(e + 1)) e++;
    m    = ax / pow2(e) * 1024.0;
    fi   = int'($floor(m));
    frac = m - real'(fi);
    if (frac > 0.5 || (frac == 0.5 && (fi % 2) == 1)) fi++;
    if (fi == 2048) begin
      fi = 1024;
      e++;
    end
    if (e > 15) begin
`ifdef FPU16_ACC_SAT_EN
      return {s, 15'h7BFF};
`else
      return {s, 15'h7C00};
`endif
    end
    return {s, 5'(e + 15), 10'(fi - 1024)};
  endfunction

  function automatic logic [15:0] refAdd(input logic [15:0] a, input logic [15:0] b);
    bit  an, bn, ai, bi;
    real sum;
    an = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    ai = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    bi = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    if (an || bn) return 16'h7E00;
    if (ai && bi && (a[15] != b[15])) return 16'h7E00;
    if (ai) return {a[15], 15'h7C00};
    if (bi) return {b[15], 15'h7C00};
    if (a[14:10] == 5'd0 && b[14:10] == 5'd0) return {a[15] & b[15], 15'h0000};
    sum = toReal(a) + toReal(b);
    if (sum == 0.0) return 16'h0000;
    return fromReal(sum);
  endfunction

  function automatic logic [15:0] randHalf();
    logic [15:0] r;
    logic [15:0] specials [6] = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h8000, 16'h0001, 16'h83FF};
    r = 16'($urandom);
    case ($urandom_range(0, 11))
      0:       return r;
      1:       return specials[$urandom_range(0, 5)];
      2:       return {r[15], 5'($urandom_range(28, 30)), r[9:0]};
      default: return {r[15], 5'($urandom_range(12, 18)), r[9:0]};
    endcase
  endfunction

  // Offer one beat after a gap of idle cycles and wait, within a bound, for it
  // to transfer. Then advance the reference model.
  task automatic applyStimulus(input logic [15:0] d, input bit last, input int gap);
    int n = 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (model_first) begin
      model_acc = refAdd(16'h0000, d);
      model_cnt = 1;
    end else begin
      model_acc = refAdd(model_acc, d);
      if (model_cnt < CNT_MAX) model_cnt++;
    end
    model_first = last;
  endtask

  // Run right after the last beat transfers. Checks the result, holds it under
  // back-pressure, then hands it off and checks the return to IDLE.
  task automatic collectSum(input string tag, input logic [15:0] exp_sum,
                            input int exp_cnt, input int hold);
    checkOutput({tag, "_valid_rise"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_ready_low"},  32'(bus.in_ready),  32'd0);
    checkOutput({tag, "_sum"},        32'(bus.out_sum),   32'(exp_sum));
    checkOutput({tag, "_count"},      32'(bus.out_count), 32'(exp_cnt));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({tag, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
      checkOutput({tag, "_hold_sum"},   32'(bus.out_sum),   32'(exp_sum));
      checkOutput({tag, "_hold_count"}, 32'(bus.out_count), 32'(exp_cnt));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    int terms;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_ready", 32'(bus.in_ready),  32'd0);
    checkOutput("rst_count", 32'(bus.out_count), 32'd0);
    checkOutput("rst_sum",   32'(bus.out_sum),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", 32'(bus.in_ready), 32'd1);

    applyStimulus(16'h3C00, 1'b0, 0);
    applyStimulus(16'h4000, 1'b0, 0);
    applyStimulus(16'h4200, 1'b1, 0);
    collectSum("three_terms", 16'h4600, 3, 0);

    applyStimulus(16'h3800, 1'b1, 0);
    collectSum("backpressure", 16'h3800, 1, 5);

    applyStimulus(16'h3C00, 1'b0, 0);
    applyStimulus(16'hBC00, 1'b1, 1);
    collectSum("cancel_zero", 16'h0000, 2, 0);

    applyStimulus(16'h7C00, 1'b0, 0);
    applyStimulus(16'hFC00, 1'b1, 0);
    collectSum("inf_minus_inf", 16'h7E00, 2, 0);

    applyStimulus(16'h7E00, 1'b0, 0);
    applyStimulus(16'h3C00, 1'b1, 0);
    collectSum("nan_sticky", 16'h7E00, 2, 0);

    applyStimulus(16'h7BFF, 1'b0, 0);
    applyStimulus(16'h7BFF, 1'b1, 0);
`ifdef FPU16_ACC_SAT_EN
    collectSum("overflow", 16'h7BFF, 2, 0);
`else
    collectSum("overflow", 16'h7C00, 2, 0);
`endif

    applyStimulus(16'h3C00, 1'b0, 0);
    applyStimulus(16'h1000, 1'b1, 0);
    collectSum("tie_even_down", 16'h3C00, 2, 0);

    applyStimulus(16'h3C01, 1'b0, 0);
    applyStimulus(16'h1000, 1'b1, 0);
    collectSum("tie_even_up", 16'h3C02, 2, 0);

    applyStimulus(16'h0400, 1'b0, 0);
    applyStimulus(16'h8001, 1'b1, 0);
    collectSum("subnormal_in", 16'h0400, 2, 0);

    applyStimulus(16'h0401, 1'b0, 0);
    applyStimulus(16'h8400, 1'b1, 0);
    collectSum("subnormal_out", 16'h0000, 2, 0);

    applyStimulus(16'h3C00, 1'b0, 0);
    applyStimulus(16'h4000, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_ready", 32'(bus.in_ready),  32'd0);
    checkOutput("midrst_count", 32'(bus.out_count), 32'd0);
    model_first = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_ready_back", 32'(bus.in_ready), 32'd1);
    applyStimulus(16'h4000, 1'b1, 0);
    collectSum("after_reset", 16'h4000, 1, 0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(16'h0000, (i == 299), 0);
    end
    collectSum("count_saturate", 16'h0000, CNT_MAX, 0);

    for (int s = 0; s < 40; s++) begin
      terms = $urandom_range(1, 8);
      for (int t = 0; t < terms; t++) begin
        applyStimulus(randHalf(), (t == terms - 1), $urandom_range(0, 2));
      end
      collectSum("random", model_acc, model_cnt, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu16_accumulator.md
FPU16_ACCUMULATOR -- requirements
Module: fpu16_accumulator

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of the accepted-term counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  product beat offered by the upstream fpu16_multiplier.
REQ-005 SHALL have port: in_ready  output  1  accumulator can accept a beat this cycle.
REQ-006 SHALL have port: in_data  input  16  IEEE-754 binary16 product.
REQ-007 SHALL have port: in_last  input  1  marks the final term of the current sum.
REQ-008 SHALL have port: out_valid  output  1  completed sum available.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts the sum.
REQ-010 SHALL have port: out_sum  output  16  binary16 accumulated result.
REQ-011 SHALL have port: out_count  output  CNT_W  number of terms in out_sum.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, ACC, HOLD.
REQ-013 SHALL transfer an input beat only when in_valid and in_ready are both 1 on a rising edge.
REQ-014 SHALL drive in_ready=1 in IDLE and ACC and in_ready=0 in HOLD.
REQ-015 SHALL, on a beat accepted in IDLE, load acc = 0x0000 + in_data and count = 1; on a beat in ACC, set acc = acc + in_data and count = count+1.
REQ-016 SHALL move IDLE->ACC on an accepted beat with in_last=0, and IDLE/ACC->HOLD on an accepted beat with in_last=1.
REQ-017 SHALL assert out_valid exactly when in HOLD, so out_valid rises one cycle after the last beat is accepted.
REQ-018 SHALL keep out_sum and out_count stable while out_valid=1 and out_ready=0.
REQ-019 SHALL move HOLD->IDLE when out_valid and out_ready are both 1; in_ready reasserts the following cycle, with no same-cycle bypass.
REQ-020 SHALL keep acc, count and state unchanged in IDLE/ACC when no beat transfers; bubbles are allowed.
REQ-021 SHALL compute each addition as the exact sum, rounded to nearest-even, in the same cycle the beat is accepted.
REQ-022 SHALL treat subnormal inputs as signed zero and flush subnormal results to +0x0000.
REQ-023 SHALL return +0x0000 for an exact-zero sum of opposite-sign operands, and 0x8000 for -0 + -0.
REQ-024 SHALL output 0x7E00 for any NaN operand or for +inf + -inf; NaN is sticky until HOLD->IDLE.
REQ-025 SHALL propagate infinities with sign when no opposite infinity is present.
REQ-026 SHALL saturate count at 2^CNT_W-1 instead of wrapping.
REQ-027 SHALL drive out_sum and out_count from registers, with no combinational path from inputs.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state=IDLE, acc=0x0000, count=0, out_valid=0 and in_ready=0.
REQ-029 SHALL drive in_ready=1 from the first rising edge after rst_n deasserts.
REQ-030 SHALL discard any partial sum or pending output when reset asserts mid-operation.

Configuration
REQ-031 SHALL, when FPU16_ACC_SAT_EN is defined, replace finite-operand overflow results with the signed maximum finite value (0x7BFF/0xFBFF); input infinities and NaN still follow REQ-024/025.
REQ-032 SHALL, when FPU16_ACC_SAT_EN is undefined, round finite overflow to signed infinity (0x7C00/0xFC00).

Verification
REQ-033 SHALL cover: beats 0x3C00, 0x4000, 0x4200(last), out_ready=1 -> out_valid 1 cycle after third beat, out_sum=0x4600, out_count=3.
REQ-034 SHALL cover: single beat 0x3800 with in_last=1 and out_ready held 0 for 5 cycles -> in_ready=0, out_sum=0x3800 and out_count=1 stable, then HOLD->IDLE on out_ready.
REQ-035 SHALL cover: 0x3C00 then 0xBC00(last) -> out_sum=0x0000; 0x7C00 then 0xFC00(last) -> out_sum=0x7E00.
REQ-036 SHALL cover: 0x7BFF then 0x7BFF(last) -> out_sum=0x7C00 without the macro and 0x7BFF with FPU16_ACC_SAT_EN.
REQ-037 SHALL cover: rst_n pulled low after two accepted beats -> out_valid=0 and in_ready=0 during reset; next sum 0x4000(last) -> out_sum=0x4000, out_count=1.
REQ-038 SHALL cover: 300 beats of 0x0000 with the last flagged, CNT_W=8 -> out_count=255, out_sum=0x0000.
